pe_ws_param: RTL and testbench

PE_WS_PARAM -- requirements
Module: pe_ws_param

---
 rtl/pe_pkg.sv | 15 +
 rtl/pe_mac_unit.sv | 59 +++++
 rtl/pe_ws_param.sv | 134 +++++++++++++
 tb/tb_pe_ws_param.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the weight-stationary PE: FSM encoding
// and default operand/accumulator widths.
package pe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        READY = 2'd1,
        RUN   = 2'd2
    } pe_state_e;

    localparam int PE_DATA_W = 16;
    localparam int PE_ACC_W  = 40;
    localparam bit PE_SIGNED = 1'b1;

endpackage

// File: rtl/pe_mac_unit.sv
// Combinational multiply, extend and add for one PE.
// Define PE_WS_SAT_EN to clamp the sum instead of wrapping.
module pe_mac_unit
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_W,
    parameter int ACC_WIDTH  = PE_ACC_W,
    parameter bit SIGNED     = PE_SIGNED
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] w,
    input  logic [ACC_WIDTH-1:0]  psum,
    output logic [ACC_WIDTH-1:0]  sum
`ifdef PE_WS_SAT_EN
    ,
    output logic                  ovf
`endif
);

    localparam int PW = 2 * DATA_WIDTH;

    logic [PW-1:0]        a_x;
    logic [PW-1:0]        w_x;
    logic [PW-1:0]        prod;
    logic [ACC_WIDTH-1:0] prod_x;

    always_comb begin
        a_x  = {{DATA_WIDTH{SIGNED & a[DATA_WIDTH-1]}}, a};
        w_x  = {{DATA_WIDTH{SIGNED & w[DATA_WIDTH-1]}}, w};
        prod = a_x * w_x;
        if (SIGNED) prod_x = ACC_WIDTH'($signed(prod));
        else        prod_x = ACC_WIDTH'(prod);
    end

`ifdef PE_WS_SAT_EN
    localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [ACC_WIDTH-1:0] UMAX = {ACC_WIDTH{1'b1}};

    logic [ACC_WIDTH:0] wide;

    // One guard bit makes the sum exact; overflow shows in the top bits.
    always_comb begin
        wide = {SIGNED & psum[ACC_WIDTH-1], psum}
             + {SIGNED & prod_x[ACC_WIDTH-1], prod_x};
        if (SIGNED) begin
            ovf = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
            sum = ovf ? (wide[ACC_WIDTH] ? SMIN : SMAX)
                      : wide[ACC_WIDTH-1:0];
        end else begin
            ovf = wide[ACC_WIDTH];
            sum = ovf ? UMAX : wide[ACC_WIDTH-1:0];
        end
    end
`else
    assign sum = psum + prod_x;
`endif

endmodule

// File: rtl/pe_ws_param.sv
// Weight-stationary MAC PE with shadow/active weights and FSM.
// Optional saturation and sticky sat_flag via PE_WS_SAT_EN.
module pe_ws_param
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_W,
    parameter int ACC_WIDTH  = PE_ACC_W,
    parameter bit SIGNED     = PE_SIGNED
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_load,
    input  logic [DATA_WIDTH-1:0] w_in,
    input  logic                  w_swap,
    output logic [DATA_WIDTH-1:0] w_out,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic                  a_vld_in,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic                  a_vld_out,
    input  logic                  bd_pe,
    input  logic [ACC_WIDTH-1:0]  psum_in,
    output logic [ACC_WIDTH-1:0]  psum_out,
    output logic                  psum_vld,
    output logic                  w_ready,
    output logic                  sat_flag
);

    if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_bad_acc
        $error("ACC_WIDTH must be at least 2*DATA_WIDTH");
    end

    pe_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [DATA_WIDTH-1:0] active_q, active_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic                  shadow_vld_q, shadow_vld_d;
    logic                  a_vld_q, a_vld_d;
    logic                  psum_vld_q, psum_vld_d;
    logic [ACC_WIDTH-1:0]  psum_q, psum_d;
    logic [ACC_WIDTH-1:0]  mac_psum;
    logic [ACC_WIDTH-1:0]  mac_sum;
    logic [DATA_WIDTH-1:0] mac_w;
    logic                  swap_ok;

    assign w_ready  = (state_q != EMPTY);
    assign swap_ok  = w_swap & shadow_vld_q;
    assign mac_psum = bd_pe ? '0 : psum_in;
    // Without an active weight the product must count as zero.
    assign mac_w    = w_ready ? active_q : '0;

`ifdef PE_WS_SAT_EN
    logic mac_ovf;
    logic sat_q, sat_d;
`endif

    pe_mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SIGNED     (SIGNED)
    ) u_mac (
        .a    (a_in),
        .w    (mac_w),
        .psum (mac_psum),
        .sum  (mac_sum)
`ifdef PE_WS_SAT_EN
        ,
        .ovf  (mac_ovf)
`endif
    );

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
        active_d     = active_q;
        psum_d       = psum_q;
        psum_vld_d   = a_vld_in;
        a_d          = a_in;
        a_vld_d      = a_vld_in;
        if (w_load) begin
            shadow_d     = w_in;
            shadow_vld_d = 1'b1;
        end
        if (swap_ok) active_d = shadow_q;
        if (a_vld_in) psum_d = mac_sum;
        unique case (state_q)
            EMPTY:      if (swap_ok) state_d = READY;
            READY, RUN: state_d = a_vld_in ? RUN : READY;
            default:    state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= EMPTY;
            shadow_q     <= '0;
            shadow_vld_q <= 1'b0;
            active_q     <= '0;
            psum_q       <= '0;
            psum_vld_q   <= 1'b0;
            a_q          <= '0;
            a_vld_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
            active_q     <= active_d;
            psum_q       <= psum_d;
            psum_vld_q   <= psum_vld_d;
            a_q          <= a_d;
            a_vld_q      <= a_vld_d;
        end
    end

`ifdef PE_WS_SAT_EN
    assign sat_d = sat_q | (a_vld_in & mac_ovf);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sat_q <= 1'b0;
        else      sat_q <= sat_d;
    end

    assign sat_flag = sat_q;
`else
    assign sat_flag = 1'b0;
`endif

    assign w_out     = shadow_q;
    assign a_out     = a_q;
    assign a_vld_out = a_vld_q;
    assign psum_out  = psum_q;
    assign psum_vld  = psum_vld_q;

endmodule

// File: tb/tb_pe_ws_param.sv
// Bench for pe_ws_param: directed cases plus random stimulus
// compared every cycle against an arithmetic reference model.
module tb_pe_ws_param;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          w_load = 1'b0;
    logic [DW-1:0] w_in = '0;
    logic          w_swap = 1'b0;
    logic [DW-1:0] w_out;
    logic [DW-1:0] a_in = '0;
    logic          a_vld_in = 1'b0;
    logic [DW-1:0] a_out;
    logic          a_vld_out;
    logic          bd_pe = 1'b0;
    logic [AW-1:0] psum_in = '0;
    logic [AW-1:0] psum_out;
    logic          psum_vld;
    logic          w_ready;
    logic          sat_flag;

    always #5 clk = ~clk;

    pe_ws_param #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .SIGNED     (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .w_load    (w_load),
        .w_in      (w_in),
        .w_swap    (w_swap),
        .w_out     (w_out),
        .a_in      (a_in),
        .a_vld_in  (a_vld_in),
        .a_out     (a_out),
        .a_vld_out (a_vld_out),
        .bd_pe     (bd_pe),
        .psum_in   (psum_in),
        .psum_out  (psum_out),
        .psum_vld  (psum_vld),
        .w_ready   (w_ready),
        .sat_flag  (sat_flag)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: shadow/active weights and the expected outputs.
    logic [DW-1:0] m_sh, m_act, m_a;
    logic [AW-1:0] m_psum;
    bit            m_shv, m_hw, m_avld, m_vld, m_sat;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_sh = '0; m_act = '0; m_a = '0; m_psum = '0;
            m_shv = 0; m_hw = 0; m_avld = 0; m_vld = 0; m_sat = 0;
        end else begin
            longint p, s;
            p = m_hw ? longint'($signed(a_in)) * longint'($signed(m_act))
                     : 64'sd0;
            s = (bd_pe ? 64'sd0 : longint'($signed(psum_in))) + p;
            if (a_vld_in) begin
`ifdef PE_WS_SAT_EN
                if (s > MAXV) begin
                    s = MAXV; m_sat = 1;
                end else if (s < MINV) begin
                    s = MINV; m_sat = 1;
                end
`endif
                m_psum = s[AW-1:0];
            end
            m_vld = a_vld_in;
            if (w_swap && m_shv) begin
                m_act = m_sh; m_hw = 1;
            end
            if (w_load) begin
                m_sh = w_in; m_shv = 1;
            end
            m_a = a_in;
            m_avld = a_vld_in;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("m_w_out", w_out, m_sh);
            chk("m_w_ready", w_ready, m_hw);
            chk("m_a_out", a_out, m_a);
            chk("m_a_vld_out", a_vld_out, m_avld);
            chk("m_psum_vld", psum_vld, m_vld);
            chk("m_psum_out", psum_out, m_psum);
            chk("m_sat_flag", sat_flag, m_sat);
        end
    end

    initial begin
        #12;
        chk("rst_psum", psum_out, 0);
        chk("rst_wready", w_ready, 0);
        chk("rst_avld", a_vld_out, 0);
        rst = 1'b1;
        tick();

        w_swap = 1; tick(); w_swap = 0;
        chk("swap_no_shadow", w_ready, 0);

        a_vld_in = 1; a_in = 3; psum_in = 42; tick();
        chk("empty_psum", psum_out, 42);
        chk("empty_vld", psum_vld, 1);
        chk("empty_wready", w_ready, 0);
        a_vld_in = 0; tick();
        chk("empty_vld_drop", psum_vld, 0);

        w_load = 1; w_in = 3; tick(); w_load = 0;
        chk("load_w_out", w_out, 3);
        w_swap = 1; tick(); w_swap = 0;
        chk("swap_wready", w_ready, 1);
        a_vld_in = 1; a_in = 5; psum_in = 10; tick();
        chk("basic_psum", psum_out, 25);
        chk("basic_vld", psum_vld, 1);
        a_vld_in = 0; tick();
        chk("hold_psum", psum_out, 25);
        chk("hold_vld", psum_vld, 0);

        w_load = 1; w_in = 16'hFFFE; tick(); w_load = 0;
        w_swap = 1; tick(); w_swap = 0;
        a_vld_in = 1; a_in = 7; bd_pe = 1; psum_in = 99; tick();
        chk("bd_neg_psum", psum_out, 32'hFFFF_FFF2);

        a_vld_in = 0; w_load = 1; w_in = 4; tick(); w_load = 0;
        a_vld_in = 1; a_in = 1; tick();
        chk("run_old_w", psum_out, 32'hFFFF_FFFE);
        a_in = 2; w_load = 1; w_in = 9; w_swap = 1; tick();
        w_load = 0; w_swap = 0;
        chk("swap_same_cyc", psum_out, 32'hFFFF_FFFC);
        tick();
        chk("swap_next_op", psum_out, 8);
        chk("shadow_nine", w_out, 9);
        a_vld_in = 0; w_swap = 1; tick(); w_swap = 0;
        a_vld_in = 1; a_in = 1; tick();
        chk("swap_nine", psum_out, 9);

        a_vld_in = 0; w_load = 1; w_in = 1; tick(); w_load = 0;
        w_swap = 1; tick(); w_swap = 0;
        a_vld_in = 1; a_in = 1; bd_pe = 0; psum_in = 32'h7FFF_FFFF;
        tick();
`ifdef PE_WS_SAT_EN
        chk("ovf_psum", psum_out, 32'h7FFF_FFFF);
        chk("ovf_flag", sat_flag, 1);
`else
        chk("ovf_psum", psum_out, 32'h8000_0000);
        chk("ovf_flag", sat_flag, 0);
`endif

        a_in = 3; psum_in = 5; tick();
        chk("pre_rst_psum", psum_out, 8);
        #3 rst = 1'b0;
        #1;
        chk("async_psum", psum_out, 0);
        chk("async_vld", psum_vld, 0);
        chk("async_aout", a_out, 0);
        chk("async_avld", a_vld_out, 0);
        chk("async_wready", w_ready, 0);
        chk("async_wout", w_out, 0);
        chk("async_sat", sat_flag, 0);
        a_vld_in = 0;
        #2 rst = 1'b1;
        tick(); tick();
        chk("post_rst_vld", psum_vld, 0);

        for (int i = 0; i < 3000; i++) begin
            w_load   = ($urandom_range(0, 3) == 0);
            w_swap   = ($urandom_range(0, 3) == 0);
            w_in     = DW'($urandom);
            a_vld_in = ($urandom_range(0, 3) != 0);
            a_in     = DW'($urandom);
            bd_pe    = ($urandom_range(0, 3) == 0);
            psum_in  = $urandom;
            if ($urandom_range(0, 3) == 0)
                psum_in = $urandom_range(0, 1) ? 32'h7FFF_FF00
                                               : 32'h8000_00FF;
            tick();
        end
        a_vld_in = 0; w_load = 0; w_swap = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
